// File: rtl/lea_nibble_sub_ctrl_if.sv
// Operand/result handshake bundle for the nibble-serial subtractor controller.
// master: producer/consumer side (drives operands and out_ready).
// slave : controller side (drives in_ready, out_valid, d, borrow_out).
interface lea_nibble_sub_ctrl_if #(
  parameter int NIBBLES = 8
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         borrow_out;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, d, borrow_out
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, d, borrow_out
  );
endinterface

// File: rtl/lea_nibble_sub_ctrl.sv
// Purpose: sequences a W-bit subtraction a-b through an external 4-bit subtractor, one nibble per cycle.
// Latency: out_valid rises NIBBLES edges after the accepting edge; one result per NIBBLES+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
// Ports: clk, rst_n (async active-low); bus (slave modport: in_valid/in_ready/a/b, out_valid/out_ready/d/borrow_out);
//        busy (high in RUN); sub_a/sub_b/sub_bin to the external subtractor, sub_d/sub_bout back from it.
module lea_nibble_sub_ctrl #(
  parameter int NIBBLES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lea_nibble_sub_ctrl_if.slave bus,
  output logic                 busy,
  output logic [3:0]           sub_a,
  output logic [3:0]           sub_b,
  output logic                 sub_bin,
  input  logic [3:0]           sub_d,
  input  logic                 sub_bout
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [KW-1:0]  k;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [W-1:0]   d_reg;
  logic           borrow_reg;
  logic           bout_reg;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and decoded outputs
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    sub_a         = 4'd0;
    sub_b         = 4'd0;
    sub_bin       = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        // Current nibble of the captured operands; the borrow register was
        // cleared on accept, so the least significant nibble sees no borrow.
        sub_a   = a_reg[{k, 2'b00} +: 4];
        sub_b   = b_reg[{k, 2'b00} +: 4];
        sub_bin = borrow_reg;
        if (k == K_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, nibble-serial difference assembly, borrow chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k          <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      d_reg      <= '0;
      borrow_reg <= 1'b0;
      bout_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg      <= bus.a;
            b_reg      <= bus.b;
            k          <= '0;
            borrow_reg <= 1'b0;
          end
        end
        RUN: begin
          // Upper nibbles of d still hold the previous result until reached.
          d_reg[{k, 2'b00} +: 4] <= sub_d;
          borrow_reg             <= sub_bout;
          if (k == K_LAST) begin
            k        <= '0;
            bout_reg <= sub_bout;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.d          = d_reg;
  assign bus.borrow_out = bout_reg;

endmodule

// File: tb/tb_lea_nibble_sub_ctrl.sv
// Bench for lea_nibble_sub_ctrl: directed cases plus 1000 random operand pairs.
// Expected results come from whole-word arithmetic (a-b, a<b, masked-prefix compares).
// An ideal 4-bit subtractor is modelled here as the external datapath.
module tb_lea_nibble_sub_ctrl;

  localparam int NIB = 8;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [3:0] sub_a;
  logic [3:0] sub_b;
  logic       sub_bin;
  logic [3:0] sub_d;
  logic       sub_bout;
  logic [4:0] sub_full;

  int errs;
  int checks;

  lea_nibble_sub_ctrl_if #(.NIBBLES(NIB)) bus ();

  lea_nibble_sub_ctrl #(.NIBBLES(NIB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .sub_a    (sub_a),
    .sub_b    (sub_b),
    .sub_bin  (sub_bin),
    .sub_d    (sub_d),
    .sub_bout (sub_bout)
  );

  // External 4-bit subtractor
  assign sub_full = {1'b0, sub_a} - {1'b0, sub_b} - {4'd0, sub_bin};
  assign sub_d    = sub_full[3:0];
  assign sub_bout = sub_full[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction. keep_valid keeps in_valid asserted with junk operands
  // during RUN/DONE and leaves it high on exit (next caller supplies operands).
  task automatic do_txn(input logic [31:0] ta, input logic [31:0] tb_v,
                        input int stall, input bit keep_valid, input bit rnd_ordy);
    logic [31:0] exp_d;
    logic        exp_b;
    logic [63:0] mask;
    int          n;
    exp_d = ta - tb_v;
    exp_b = (ta < tb_v);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_wait", bus.in_ready, 1);
    bus.a        = ta;
    bus.b        = tb_v;
    bus.in_valid = 1'b1;
    tick();
    if (keep_valid) begin
      bus.a = $urandom;
      bus.b = $urandom;
    end else begin
      bus.in_valid = 1'b0;
    end
    for (int k = 0; k < NIB; k++) begin
      mask = (64'd1 << (4 * k)) - 64'd1;
      chk("run_busy", busy, 1);
      chk("run_in_ready", bus.in_ready, 0);
      chk("run_out_valid", bus.out_valid, 0);
      chk("sub_a", sub_a, (ta >> (4 * k)) & 32'hF);
      chk("sub_b", sub_b, (tb_v >> (4 * k)) & 32'hF);
      chk("sub_bin", sub_bin, (k == 0) ? 1'b0 : ((64'(ta) & mask) < (64'(tb_v) & mask)));
      bus.out_ready = rnd_ordy ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      if (keep_valid) begin
        bus.a = $urandom;
        bus.b = $urandom;
      end
    end
    bus.out_ready = 1'b0;
    chk("latency_out_valid", bus.out_valid, 1);
    chk("done_busy", busy, 0);
    chk("done_sub_a", sub_a, 0);
    chk("done_sub_bin", sub_bin, 0);
    chk("d", bus.d, exp_d);
    chk("borrow_out", bus.borrow_out, exp_b);
    for (int s = 0; s < stall; s++) begin
      tick();
      if (keep_valid) begin
        bus.a = $urandom;
        bus.b = $urandom;
      end
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_d", bus.d, exp_d);
      chk("stall_borrow", bus.borrow_out, exp_b);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("post_out_valid", bus.out_valid, 0);
    chk("post_in_ready", bus.in_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_d", bus.d, exp_d);
    chk("post_borrow", bus.borrow_out, exp_b);
  endtask

  initial begin
    int seen;
    logic [31:0] ra;
    logic [31:0] rb;
    errs          = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (3) tick();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_d", bus.d, 0);
    chk("rst_borrow", bus.borrow_out, 0);
    chk("rst_sub_a", sub_a, 0);
    chk("rst_sub_b", sub_b, 0);
    chk("rst_sub_bin", sub_bin, 0);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", bus.in_ready, 1);

    // Directed cases
    do_txn(32'h0000_0009, 32'h0000_0003, 0, 1'b0, 1'b0);
    do_txn(32'h0000_0000, 32'h0000_0001, 0, 1'b0, 1'b0);
    do_txn(32'h1234_5678, 32'h1234_5678, 5, 1'b0, 1'b0);
    do_txn(32'hA5A5_0F0F, 32'h5A5A_F0F0, 2, 1'b1, 1'b1);
    do_txn(32'h0000_1000, 32'h0000_0FFF, 1, 1'b0, 1'b0);

    // Reset in the middle of RUN (k = 4)
    bus.a        = 32'hDEAD_BEEF;
    bus.b        = 32'h0000_0001;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_d", bus.d, 0);
    chk("arst_borrow", bus.borrow_out, 0);
    chk("arst_sub_a", sub_a, 0);
    chk("arst_sub_b", sub_b, 0);
    chk("arst_sub_bin", sub_bin, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    chk("no_valid_after_rst", seen, 0);
    do_txn(32'h8000_0000, 32'h7FFF_FFFF, 0, 1'b0, 1'b0);

    // Random transactions
    for (int t = 0; t < 1000; t++) begin
      ra = $urandom;
      rb = $urandom;
      if (t % 50 == 0) rb = ra;
      if (t % 37 == 0) ra = rb - 1;
      do_txn(ra, rb, $urandom_range(0, 2), (t != 999) && ($urandom_range(0, 3) == 0),
             1'b1);
      if (bus.in_valid == 1'b0 && $urandom_range(0, 1) == 1) tick();
    end
    bus.in_valid = 1'b0;
    tick();
    chk("final_in_ready", bus.in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/lea_nibble_sub_ctrl.md
LEA_NIBBLE_SUB_CTRL -- requirements
Module: lea_nibble_sub_ctrl

Interface
REQ-001 Parameter: NIBBLES, default 8, number of 4-bit digits per operand (word width W = 4*NIBBLES).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  block accepts operands; high only in IDLE.
REQ-006 a  input  W  minuend.
REQ-007 b  input  W  subtrahend.
REQ-008 out_valid  output  1  result available; high only in DONE.
REQ-009 out_ready  input  1  consumer takes result.
REQ-010 d  output  W  registered difference a-b mod 2^W.
REQ-011 borrow_out  output  1  registered final borrow (1 when a<b unsigned).
REQ-012 busy  output  1  high in RUN.
REQ-013 sub_a  output  4  nibble of captured a to external 4-bit subtractor.
REQ-014 sub_b  output  4  nibble of captured b to external 4-bit subtractor.
REQ-015 sub_bin  output  1  borrow into external subtractor.
REQ-016 sub_d  input  4  difference nibble from external subtractor (combinational, same cycle).
REQ-017 sub_bout  input  1  borrow out of external subtractor.

Function
REQ-018 FSM states IDLE, RUN, DONE; encoding free.
REQ-019 IDLE: in_ready=1; on in_valid=1 at an edge, capture a, b into operand registers, clear nibble index k to 0, clear borrow register, go to RUN.
REQ-020 in_valid=0 in IDLE: remain IDLE, no register changes.
REQ-021 RUN: sub_a=a_reg[4k+3:4k], sub_b=b_reg[4k+3:4k], sub_bin=borrow register (0 when k=0).
REQ-022 RUN, each edge: d[4k+3:4k] <= sub_d, borrow register <= sub_bout, k <= k+1.
REQ-023 RUN with k=NIBBLES-1: after that edge's updates, go to DONE and load borrow_out <= sub_bout; k returns to 0 (no wrap past NIBBLES-1).
REQ-024 Latency: out_valid asserts exactly NIBBLES edges after the accepting edge (8 for default).
REQ-025 Outside RUN: sub_a=0, sub_b=0, sub_bin=0.
REQ-026 DONE: out_valid=1; d and borrow_out held stable until transfer.
REQ-027 DONE with out_ready=1 at an edge: go to IDLE; d and borrow_out keep last values, out_valid drops.
REQ-028 in_valid during RUN or DONE ignored; operands not sampled (in_ready=0).
REQ-029 out_ready outside DONE has no effect.
REQ-030 Back-to-back: at least one IDLE cycle between consecutive transactions; throughput one result per NIBBLES+2 cycles.
REQ-031 Operand registers unchanged during RUN even if a/b inputs change.
REQ-032 Wrap-around: a<b yields d = a-b+2^W, borrow_out=1; a=b yields d=0, borrow_out=0.
REQ-033 d bits for nibbles not yet processed in RUN retain prior-transaction values; d only valid when out_valid=1.

Reset
REQ-034 rst_n=0 asynchronously forces IDLE, k=0, borrow register=0, operand registers=0, d=0, borrow_out=0, out_valid=0, busy=0, in_ready=1 once released.
REQ-035 Reset asserted mid-RUN or in DONE discards the transaction; no out_valid follows.
REQ-036 First transaction accepted on first edge after rst_n deasserts with in_valid=1.

Verification
REQ-037 a=0x0000_0009, b=0x0000_0003, in_valid pulse -> out_valid 8 edges later, d=0x0000_0006, borrow_out=0.
REQ-038 a=0x0000_0000, b=0x0000_0001 -> d=0xFFFF_FFFF, borrow_out=1; sub_bin=1 in cycles k=1..7.
REQ-039 a=0x1234_5678, b=0x1234_5678 -> d=0, borrow_out=0; out_ready held low 5 cycles -> out_valid and d stable throughout, then released on out_ready.
REQ-040 in_valid held high with new a/b during RUN and DONE -> operands ignored, second transaction accepted only after IDLE cycle, results match each pair.
REQ-041 rst_n pulsed low at k=4 -> all outputs 0 immediately, no out_valid; next transaction a=0x8000_0000, b=0x7FFF_FFFF -> d=0x0000_0001, borrow_out=0.
REQ-042 Random a/b with external 4-bit reference subtractor, 1000 transactions -> d=(a-b) mod 2^32, borrow_out=(a<b).
